// File: rtl/spi_serdes_pkg.sv
// Shared types and constants for the SPI word serialiser/deserialiser.
// TX state encoding, bytes-per-word helper and the default idle fill byte.
package spi_serdes_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_LOADED = 2'd2
  } tx_state_t;

  localparam logic [7:0] FILL_BYTE_DEFAULT = 8'hFF;

  function automatic int bytes_per_word(input int data_width, input int spi_data_width);
    return data_width / spi_data_width;
  endfunction

endpackage

// File: rtl/spi_word_serdes_rx.sv
// RX byte-to-word assembler: first received byte lands in the most significant lane,
// and the completed word is presented with a one-cycle rx_wr strobe.
module spi_rx_assembler
  import spi_serdes_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int SPI_DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      byte_valid,
  input  logic [SPI_DATA_WIDTH-1:0] byte_data,
  input  logic                      frame_end,
  output logic                      rx_wr,
  output logic [DATA_WIDTH-1:0]     rx_word
);

  localparam int BYTES = bytes_per_word(DATA_WIDTH, SPI_DATA_WIDTH);
  localparam int IDX_W = $clog2(BYTES);

  logic [DATA_WIDTH-1:0] acc_reg;
  logic [DATA_WIDTH-1:0] acc_next;
  logic [IDX_W-1:0]      rx_idx_reg;

  // Writing each byte into its own lane is equivalent to shifting in from the low end,
  // once the word is complete; stale lanes beyond rx_idx are always overwritten first.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign acc_next[DATA_WIDTH-1-gi*SPI_DATA_WIDTH -: SPI_DATA_WIDTH] =
        (rx_idx_reg == IDX_W'(gi)) ? byte_data
                                   : acc_reg[DATA_WIDTH-1-gi*SPI_DATA_WIDTH -: SPI_DATA_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg    <= '0;
      rx_idx_reg <= '0;
      rx_wr      <= 1'b0;
      rx_word    <= '0;
    end else begin
      rx_wr <= 1'b0;
      if (frame_end) begin
        rx_idx_reg <= '0;
      end else if (byte_valid) begin
        acc_reg <= acc_next;
        if (rx_idx_reg == IDX_W'(BYTES - 1)) begin
          rx_idx_reg <= '0;
          rx_word    <= acc_next;
          rx_wr      <= 1'b1;
        end else begin
          rx_idx_reg <= rx_idx_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_word_serdes.sv
// Word <-> byte bridge between the SPI slave core and the word-wide SPI buffers.
// Define SPI_SERDES_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module spi_word_serdes
  import spi_serdes_pkg::*;
#(
  parameter int                        DATA_WIDTH     = 32,
  parameter int                        SPI_DATA_WIDTH = 8,
  parameter logic [SPI_DATA_WIDTH-1:0] FILL_BYTE      = FILL_BYTE_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tx_avail,
  output logic                      tx_req,
  input  logic [DATA_WIDTH-1:0]     tx_word,
  output logic                      rx_wr,
  output logic [DATA_WIDTH-1:0]     rx_word,
  input  logic                      spi_frame,
  input  logic                      spi_ready,
  input  logic [SPI_DATA_WIDTH-1:0] spi_data_receive,
  output logic [SPI_DATA_WIDTH-1:0] spi_data_send,
  output logic                      tx_underrun
`ifdef SPI_SERDES_UNDERRUN_CNT_EN
  ,
  output logic [15:0]               underrun_cnt
`endif
);

  localparam int BYTES = bytes_per_word(DATA_WIDTH, SPI_DATA_WIDTH);
  localparam int IDX_W = $clog2(BYTES);

  tx_state_t             state_reg;
  logic [DATA_WIDTH-1:0] word_reg;
  logic [IDX_W-1:0]      tx_idx_reg;
  logic                  frame_reg;
  logic                  byte_valid;
  logic                  frame_end;
  logic                  underrun_event;
  logic [SPI_DATA_WIDTH-1:0] tx_lane [BYTES];

  assign byte_valid     = spi_ready & spi_frame;
  assign frame_end      = frame_reg & ~spi_frame;
  assign underrun_event = byte_valid & (state_reg != ST_LOADED);

  // The read strobe is decoded from EMPTY so a freshly consumed word refetches on the next cycle.
  assign tx_req = ~rst & tx_avail & (state_reg == ST_EMPTY);

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_tx_lane
      assign tx_lane[gi] = word_reg[DATA_WIDTH-1-gi*SPI_DATA_WIDTH -: SPI_DATA_WIDTH];
    end
  endgenerate

  always_comb begin
    spi_data_send = FILL_BYTE;
    if (state_reg == ST_LOADED) spi_data_send = tx_lane[tx_idx_reg];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_EMPTY;
      word_reg    <= '0;
      tx_idx_reg  <= '0;
      frame_reg   <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      frame_reg   <= spi_frame;
      tx_underrun <= underrun_event;
      case (state_reg)
        ST_EMPTY: begin
          if (tx_avail) state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          word_reg   <= tx_word;
          tx_idx_reg <= '0;
          state_reg  <= ST_LOADED;
        end
        ST_LOADED: begin
          // An untouched word survives a frame end; a partly sent one is dropped.
          if (frame_end && tx_idx_reg != '0) begin
            tx_idx_reg <= '0;
            state_reg  <= ST_EMPTY;
          end else if (byte_valid) begin
            if (tx_idx_reg == IDX_W'(BYTES - 1)) begin
              tx_idx_reg <= '0;
              state_reg  <= ST_EMPTY;
            end else begin
              tx_idx_reg <= tx_idx_reg + 1'b1;
            end
          end
        end
        default: state_reg <= ST_EMPTY;
      endcase
    end
  end

`ifdef SPI_SERDES_UNDERRUN_CNT_EN
  logic        frame_start;
  logic [15:0] underrun_cnt_reg;

  assign frame_start  = spi_frame & ~frame_reg;
  assign underrun_cnt = underrun_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_cnt_reg <= '0;
    end else if (frame_start) begin
      underrun_cnt_reg <= underrun_event ? 16'd1 : 16'd0;
    end else if (underrun_event && underrun_cnt_reg != 16'hFFFF) begin
      underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
    end
  end
`endif

  spi_rx_assembler #(
    .DATA_WIDTH    (DATA_WIDTH),
    .SPI_DATA_WIDTH(SPI_DATA_WIDTH)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .byte_valid(byte_valid),
    .byte_data (spi_data_receive),
    .frame_end (frame_end),
    .rx_wr     (rx_wr),
    .rx_word   (rx_word)
  );

endmodule

// File: tb/tb_spi_word_serdes.sv
// Directed bench for spi_word_serdes: TX byte order, RX assembly, underrun,
// frame-end cleanup, back-to-back words and asynchronous reset.
module tb_spi_word_serdes;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_avail;
  logic        tx_req;
  logic [31:0] tx_word = '0;
  logic        rx_wr;
  logic [31:0] rx_word;
  logic        spi_frame;
  logic        spi_ready;
  logic [7:0]  spi_data_receive;
  logic [7:0]  spi_data_send;
  logic        tx_underrun;
`ifdef SPI_SERDES_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int req_count = 0;
  int rxwr_count = 0;
  int ur_count = 0;

  logic [31:0] tx_mem [16];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  spi_word_serdes dut (
    .clk             (clk),
    .rst             (rst),
    .tx_avail        (tx_avail),
    .tx_req          (tx_req),
    .tx_word         (tx_word),
    .rx_wr           (rx_wr),
    .rx_word         (rx_word),
    .spi_frame       (spi_frame),
    .spi_ready       (spi_ready),
    .spi_data_receive(spi_data_receive),
    .spi_data_send   (spi_data_send),
    .tx_underrun     (tx_underrun)
`ifdef SPI_SERDES_UNDERRUN_CNT_EN
    ,
    .underrun_cnt    (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Send buffer model: data_out valid one cycle after the read strobe.
  assign tx_avail = (wr_ptr != rd_ptr);

  always @(posedge clk) begin
    if (tx_req) begin
      tx_word <= tx_mem[rd_ptr % 16];
      rd_ptr  <= rd_ptr + 1;
      req_count <= req_count + 1;
    end
    if (rx_wr) rxwr_count <= rxwr_count + 1;
    if (tx_underrun) ur_count <= ur_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [31:0] w);
    tx_mem[wr_ptr % 16] = w;
    wr_ptr++;
  endtask

  task automatic spi_byte(input logic [7:0] rxb, output logic [7:0] sent);
    sent = spi_data_send;
    spi_data_receive = rxb;
    spi_ready = 1'b1;
    @(negedge clk);
    spi_ready = 1'b0;
    $display("spi byte: rx=%h tx=%h rx_wr=%b rx_word=%h underrun=%b", rxb, sent, rx_wr, rx_word, tx_underrun);
  endtask

  logic [7:0] b;
  logic [7:0] exp1 [4];
  logic [7:0] rx1  [4];
  logic [7:0] exp5 [8];

  initial begin
    rst = 1'b1; spi_frame = 1'b0; spi_ready = 1'b0; spi_data_receive = '0;
    exp1 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    rx1  = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp5 = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
    cyc(2);
    check("rst_tx_req", tx_req, 0);
    check("rst_rx_wr", rx_wr, 0);
    check("rst_rx_word", rx_word, 0);
    check("rst_underrun", tx_underrun, 0);
    check("rst_send", spi_data_send, 8'hFF);
    rst = 1'b0;
    cyc(1);

    // Prefetch outside a frame, then four bytes each way.
    push(32'hA1B2C3D4);
    #1;
    check("prefetch_req", tx_req, 1);
    cyc(2);
    spi_frame = 1'b1;
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      spi_byte(rx1[i], b);
      check($sformatf("t1_tx_byte%0d", i), b, exp1[i]);
      check($sformatf("t1_rx_wr%0d", i), rx_wr, (i == 3) ? 1 : 0);
      if (i == 3) check("t1_rx_word", rx_word, 32'h11223344);
      cyc(2);
    end
    check("t1_req_count", req_count, 1);
    check("t1_rxwr_count", rxwr_count, 1);

    // Underrun with an empty send buffer.
    for (int i = 0; i < 2; i++) begin
      spi_byte(8'hE0, b);
      check($sformatf("t3_fill%0d", i), b, 8'hFF);
      check($sformatf("t3_underrun%0d", i), tx_underrun, 1);
      cyc(2);
    end
    check("t3_ur_count", ur_count, 2);
    check("t3_req_count", req_count, 1);
`ifdef SPI_SERDES_UNDERRUN_CNT_EN
    check("t3_underrun_cnt", underrun_cnt, 2);
`endif
    spi_frame = 1'b0;
    cyc(2);
    check("t3_partial_dropped", rxwr_count, 1);

    // Frame drops mid-word on both paths.
    push(32'h55667788);
    push(32'h99AABBCC);
    cyc(4);
    check("t4_req_count_a", req_count, 2);
    spi_frame = 1'b1;
    cyc(1);
    spi_byte(8'hAA, b); check("t4_tx_b0", b, 8'h55); cyc(2);
    spi_byte(8'hBB, b); check("t4_tx_b1", b, 8'h66); cyc(2);
    spi_frame = 1'b0;
    cyc(4);
    check("t4_no_rx_wr", rxwr_count, 1);
    check("t4_refetch", req_count, 3);
    check("t4_restart_byte0", spi_data_send, 8'h99);
    spi_frame = 1'b1;
    cyc(1);
    spi_byte(8'h01, b); check("t4_tx_c0", b, 8'h99); cyc(2);
    spi_byte(8'h02, b); check("t4_tx_c1", b, 8'hAA); cyc(2);
    spi_byte(8'h03, b); check("t4_tx_c2", b, 8'hBB); cyc(2);
    spi_byte(8'h04, b); check("t4_tx_c3", b, 8'hCC);
    check("t4_rx_wr", rx_wr, 1);
    check("t4_rx_word", rx_word, 32'h01020304);
    cyc(2);
    spi_frame = 1'b0;
    cyc(2);

    // Untouched word kept across an empty frame, then two words back to back.
    push(32'h00000001);
    push(32'h00000002);
    cyc(4);
    spi_frame = 1'b1;
    cyc(1);
    spi_frame = 1'b0;
    cyc(2);
    check("t5_retained", spi_data_send, 8'h00);
    check("t5_no_refetch", req_count, 4);
    spi_frame = 1'b1;
    cyc(1);
`ifdef SPI_SERDES_UNDERRUN_CNT_EN
    check("t5_cnt_cleared", underrun_cnt, 0);
`endif
    for (int i = 0; i < 8; i++) begin
      spi_byte(8'h10 + 8'(i), b);
      check($sformatf("t5_tx_byte%0d", i), b, exp5[i]);
      if (i == 3) check("t5_rx_word0", rx_word, 32'h10111213);
      if (i == 7) check("t5_rx_word1", rx_word, 32'h14151617);
      cyc(2);
    end
    check("t5_no_underrun", ur_count, 2);
    check("t5_req_count", req_count, 5);
    check("t5_rxwr_count", rxwr_count, 4);
    spi_frame = 1'b0;
    cyc(2);

    // Reset in the middle of a word.
    push(32'hDEADBEEF);
    cyc(4);
    spi_frame = 1'b1;
    cyc(1);
    spi_byte(8'h5A, b); check("t6_tx_b0", b, 8'hDE); cyc(2);
    spi_byte(8'h5B, b); check("t6_tx_b1", b, 8'hAD); cyc(1);
    rst = 1'b1;
    #1;
    check("t6_rst_tx_req", tx_req, 0);
    check("t6_rst_rx_wr", rx_wr, 0);
    check("t6_rst_rx_word", rx_word, 0);
    check("t6_rst_underrun", tx_underrun, 0);
    check("t6_rst_send", spi_data_send, 8'hFF);
`ifdef SPI_SERDES_UNDERRUN_CNT_EN
    check("t6_rst_cnt", underrun_cnt, 0);
`endif
    cyc(2);
    spi_frame = 1'b0;
    rst = 1'b0;
    cyc(2);
    check("t6_post_send", spi_data_send, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
